// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcode/func values,
// FSM state codes, ALU operation codes and datapath mux select codes.
package mips_ctrl_pkg;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU operation codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // FSM state codes, also exported on the debug port
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_e;

  // Bundle of every control output driven toward the datapath
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal;
    logic       retire;
  } ctrl_t;

endpackage

// File: rtl/mips_alu_dec.sv
// R-type function decoder: maps func to an ALU operation and flags whether
// the function is one the datapath supports.
module mips_alu_dec
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] func_i,
  output logic [2:0] alu_ctrl_o,
  output logic       func_legal_o
);

  // Pure lookup; unsupported functions fall back to add and are flagged illegal
  always_comb begin
    alu_ctrl_o   = ALU_ADD;
    func_legal_o = 1'b1;
    case (func_i)
      FN_ADD:  alu_ctrl_o = ALU_ADD;
      FN_SUB:  alu_ctrl_o = ALU_SUB;
      FN_AND:  alu_ctrl_o = ALU_AND;
      FN_OR:   alu_ctrl_o = ALU_OR;
      FN_SLT:  alu_ctrl_o = ALU_SLT;
      default: func_legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM. Sequences fetch/decode/execute/memory/
// writeback for one instruction at a time and counts retired instructions.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_ctrl,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             illegal,
  output logic             retire,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  ctrl_t            ctrl;
  logic [2:0]       dec_alu;
  logic             func_legal;

  // The branch decision is made by the datapath's PC-enable gate
  // (pc_write_cond & zero); sequencing never depends on it.
  logic unused_zero;
  assign unused_zero = zero;

  mips_alu_dec u_alu_dec (
    .func_i       (func),
    .alu_ctrl_o   (dec_alu),
    .func_legal_o (func_legal)
  );

  // Next-state selection; op/func are held in IR from DECODE onward
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = func_legal ? S_EXEC_R : S_ILLEGAL;
          OP_ADDI:      state_d = S_EXEC_I;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: state_d = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
      S_EXEC_R:   state_d = S_ALU_WB;
      S_EXEC_I:   state_d = S_ALU_WB;
      S_ALU_WB:   state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_ILLEGAL:  state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Output decode from the state register; only the memory handshake
  // states look at mem_ready, and EXEC_R takes its ALU op from func
  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_ctrl  = ALU_ADD;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_ctrl  = ALU_ADD;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_ctrl  = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.retire     = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_we  = 1'b1;
        ctrl.iord    = 1'b1;
        ctrl.retire  = mem_ready;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_ctrl  = dec_alu;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_ctrl  = ALU_ADD;
      end
      S_ALU_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = (op == OP_RTYPE);
        ctrl.retire    = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_ctrl      = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_src        = PCSRC_ALUOUT;
        ctrl.retire        = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PCSRC_JUMP;
        ctrl.retire   = 1'b1;
      end
      S_ILLEGAL: ctrl.illegal = 1'b1;
      default:   ctrl = '0;
    endcase
  end

  // State and retired-instruction counter; reset beats a same-cycle retire
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (ctrl.retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Everything reads as zero while reset is held
  always_comb begin
    if (rst) begin
      {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src,
       alu_src_a, alu_src_b, alu_ctrl, reg_dst, mem_to_reg, reg_write,
       illegal, retire} = '0;
      instr_count = '0;
      state_o     = '0;
    end else begin
      {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src,
       alu_src_a, alu_src_b, alu_ctrl, reg_dst, mem_to_reg, reg_write,
       illegal, retire} = ctrl;
      instr_count = cnt_q;
      state_o     = state_q;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for the multicycle MIPS control FSM. A per-instruction model builds
// the expected cycle-by-cycle control trace from the instruction class and
// the memory wait counts; a narrow-counter second instance shows wraparound.
module tb_mips_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  localparam bit Y = 1'b1;
  localparam bit N = 1'b0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, zero, mem_ready;
  logic [5:0]  op, func;
  logic        mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
  logic [1:0]  pc_src, alu_src_b;
  logic        alu_src_a, reg_dst, mem_to_reg, reg_write, illegal, retire;
  logic [2:0]  alu_ctrl;
  logic [31:0] instr_count;
  logic [3:0]  state_o;

  logic        w_mem_req, w_mem_we, w_iord, w_ir_write, w_pc_write, w_pc_write_cond;
  logic [1:0]  w_pc_src, w_alu_src_b;
  logic        w_alu_src_a, w_reg_dst, w_mem_to_reg, w_reg_write, w_illegal, w_retire;
  logic [2:0]  w_alu_ctrl;
  logic [3:0]  w_instr_count;
  logic [3:0]  w_state_o;

  mips_multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .illegal(illegal), .retire(retire), .instr_count(instr_count), .state_o(state_o)
  );

  mips_multicycle_ctrl #(.CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
    .mem_req(w_mem_req), .mem_we(w_mem_we), .iord(w_iord), .ir_write(w_ir_write),
    .pc_write(w_pc_write), .pc_write_cond(w_pc_write_cond), .pc_src(w_pc_src),
    .alu_src_a(w_alu_src_a), .alu_src_b(w_alu_src_b), .alu_ctrl(w_alu_ctrl),
    .reg_dst(w_reg_dst), .mem_to_reg(w_mem_to_reg), .reg_write(w_reg_write),
    .illegal(w_illegal), .retire(w_retire), .instr_count(w_instr_count), .state_o(w_state_o)
  );

  int checks = 0;
  int errors = 0;

  logic [22:0] exp_q[$];
  logic [22:0] obs_q[$];
  bit          rdy_q[$];
  logic [31:0] model_cnt;

  function automatic logic [22:0] pk(bit mreq, bit mwe, bit io, bit irw, bit pcw, bit pcc,
                                     logic [1:0] ps, bit sa, logic [1:0] sb, logic [2:0] al,
                                     bit rdst, bit m2r, bit rw, bit ill, bit ret, logic [3:0] st);
    return {mreq, mwe, io, irw, pcw, pcc, ps, sa, sb, al, rdst, m2r, rw, ill, ret, st};
  endfunction

  function automatic logic [22:0] obs_vec();
    return {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src, alu_src_a,
            alu_src_b, alu_ctrl, reg_dst, mem_to_reg, reg_write, illegal, retire, state_o};
  endfunction

  // {legal, alu op} for an R-type function field
  function automatic logic [3:0] r_alu(logic [5:0] f);
    case (f)
      6'h20:   return {1'b1, 3'b010};
      6'h22:   return {1'b1, 3'b110};
      6'h24:   return {1'b1, 3'b000};
      6'h25:   return {1'b1, 3'b001};
      6'h2A:   return {1'b1, 3'b111};
      default: return {1'b0, 3'b010};
    endcase
  endfunction

  function automatic bit rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected trace for one instruction: fw fetch wait cycles, mw data wait cycles
  task automatic model_build(input logic [31:0] ins, input int fw, input int mw);
    logic [5:0] o, f;
    logic [3:0] ra;
    int rets;
    o = ins[31:26];
    f = ins[5:0];
    ra = r_alu(f);
    rets = 0;
    exp_q.delete();
    rdy_q.delete();
    for (int i = 0; i < fw; i++) begin
      exp_q.push_back(pk(Y,N,N,N,N,N,2'b00,N,2'b01,3'b010,N,N,N,N,N,S_FETCH)); rdy_q.push_back(N);
    end
    exp_q.push_back(pk(Y,N,N,Y,Y,N,2'b00,N,2'b01,3'b010,N,N,N,N,N,S_FETCH)); rdy_q.push_back(Y);
    exp_q.push_back(pk(N,N,N,N,N,N,2'b00,N,2'b11,3'b010,N,N,N,N,N,S_DECODE)); rdy_q.push_back(rnd());
    if (o == 6'h23 || o == 6'h2B) begin
      exp_q.push_back(pk(N,N,N,N,N,N,2'b00,Y,2'b10,3'b010,N,N,N,N,N,S_MEM_ADDR)); rdy_q.push_back(rnd());
      if (o == 6'h23) begin
        for (int i = 0; i <= mw; i++) begin
          exp_q.push_back(pk(Y,N,Y,N,N,N,2'b00,N,2'b00,3'b000,N,N,N,N,N,S_MEM_RD)); rdy_q.push_back(i == mw);
        end
        exp_q.push_back(pk(N,N,N,N,N,N,2'b00,N,2'b00,3'b000,N,Y,Y,N,Y,S_MEM_WB)); rdy_q.push_back(rnd());
      end else begin
        for (int i = 0; i <= mw; i++) begin
          exp_q.push_back(pk(Y,Y,Y,N,N,N,2'b00,N,2'b00,3'b000,N,N,N,N,(i == mw),S_MEM_WR));
          rdy_q.push_back(i == mw);
        end
      end
      rets = 1;
    end else if (o == 6'h00 && ra[3]) begin
      exp_q.push_back(pk(N,N,N,N,N,N,2'b00,Y,2'b00,ra[2:0],N,N,N,N,N,S_EXEC_R)); rdy_q.push_back(rnd());
      exp_q.push_back(pk(N,N,N,N,N,N,2'b00,N,2'b00,3'b000,Y,N,Y,N,Y,S_ALU_WB)); rdy_q.push_back(rnd());
      rets = 1;
    end else if (o == 6'h08) begin
      exp_q.push_back(pk(N,N,N,N,N,N,2'b00,Y,2'b10,3'b010,N,N,N,N,N,S_EXEC_I)); rdy_q.push_back(rnd());
      exp_q.push_back(pk(N,N,N,N,N,N,2'b00,N,2'b00,3'b000,N,N,Y,N,Y,S_ALU_WB)); rdy_q.push_back(rnd());
      rets = 1;
    end else if (o == 6'h04) begin
      exp_q.push_back(pk(N,N,N,N,N,Y,2'b01,Y,2'b00,3'b110,N,N,N,N,Y,S_BRANCH)); rdy_q.push_back(rnd());
      rets = 1;
    end else if (o == 6'h02) begin
      exp_q.push_back(pk(N,N,N,N,Y,N,2'b10,N,2'b00,3'b000,N,N,N,N,Y,S_JUMP)); rdy_q.push_back(rnd());
      rets = 1;
    end else begin
      exp_q.push_back(pk(N,N,N,N,N,N,2'b00,N,2'b00,3'b000,N,N,N,Y,N,S_ILLEGAL)); rdy_q.push_back(rnd());
    end
    model_cnt = model_cnt + 32'(rets);
  endtask

  // Apply the instruction fields and the ready pattern, recording outputs.
  // Called at posedge+1; returns at posedge+1. ncyc<0 runs the whole trace.
  task automatic run_trace(input logic [31:0] ins, input int ncyc);
    int n;
    op = ins[31:26];
    func = ins[5:0];
    obs_q.delete();
    n = (ncyc < 0) ? rdy_q.size() : ncyc;
    for (int i = 0; i < n; i++) begin
      mem_ready = rdy_q[i];
      zero = rnd();
      #1;
      obs_q.push_back(obs_vec());
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
  endtask

  // mem_we may only appear with mem_req
  always @(negedge clk) begin
    checks++;
    if (mem_we && !mem_req) begin
      errors++;
      $display("FAIL we_implies_req t=%0t mem_we=%b mem_req=%b", $time, mem_we, mem_req);
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    mem_ready = 1'b1;
    op = 6'h23;
    func = 6'h20;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({obs_vec(), instr_count} !== 55'd0) begin
        errors++;
        $display("FAIL reset_outputs cyc%0d got=%h want=0", i, {obs_vec(), instr_count});
      end
    end
    rst = 1'b0;
    mem_ready = 1'b0;
    model_cnt = '0;
    #1;
    checks++;
    if (state_o !== 4'(S_FETCH) || mem_req !== 1'b1 || instr_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_release state=%0d mem_req=%b count=%0d want state=0 mem_req=1 count=0",
               state_o, mem_req, instr_count);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_add();
    model_build(32'h02538820, 0, 0);
    run_trace(32'h02538820, -1);
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL add cyc%0d got=%h want=%h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (instr_count !== model_cnt || model_cnt !== 32'd1) begin
      errors++;
      $display("FAIL add_count got=%0d want=1", instr_count);
    end
  endtask

  task automatic test_sw_wait();
    model_build(32'hAE320000, 0, 2);
    run_trace(32'hAE320000, -1);
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL sw_wait cyc%0d got=%h want=%h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (instr_count !== model_cnt) begin
      errors++;
      $display("FAIL sw_count got=%0d want=%0d", instr_count, model_cnt);
    end
  endtask

  task automatic test_lw_beq();
    logic [31:0] prog [2] = '{32'h8E320004, 32'h12330002};
    for (int k = 0; k < 2; k++) begin
      model_build(prog[k], k, 0);
      run_trace(prog[k], -1);
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL lw_beq ins=%h cyc%0d got=%h want=%h", prog[k], i, obs_q[i], exp_q[i]);
        end
      end
      checks++;
      if (instr_count !== model_cnt) begin
        errors++;
        $display("FAIL lw_beq_count ins=%h got=%0d want=%0d", prog[k], instr_count, model_cnt);
      end
    end
  endtask

  task automatic test_j_illegal();
    logic [31:0] prog [3] = '{32'h08000010, 32'hFC000000, 32'h00000021};
    for (int k = 0; k < 3; k++) begin
      model_build(prog[k], 0, 0);
      run_trace(prog[k], -1);
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL j_illegal ins=%h cyc%0d got=%h want=%h", prog[k], i, obs_q[i], exp_q[i]);
        end
      end
      checks++;
      if (instr_count !== model_cnt) begin
        errors++;
        $display("FAIL j_illegal_count ins=%h got=%0d want=%0d", prog[k], instr_count, model_cnt);
      end
    end
  endtask

  task automatic test_reset_midflight();
    // lw stalled in MEM_RD: FETCH, DECODE, MEM_ADDR, two MEM_RD waits, then reset
    model_build(32'h8E320004, 0, 6);
    run_trace(32'h8E320004, 5);
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL midflight_pre cyc%0d got=%h want=%h", i, obs_q[i], exp_q[i]);
      end
    end
    rst = 1'b1;
    mem_ready = 1'b1;
    #1;
    checks++;
    if ({obs_vec(), instr_count} !== 55'd0) begin
      errors++;
      $display("FAIL midflight_rst_outputs got=%h want=0", {obs_vec(), instr_count});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_ready = 1'b0;
    model_cnt = '0;
    #1;
    checks++;
    if (state_o !== 4'(S_FETCH) || instr_count !== 32'd0 || w_instr_count !== 4'd0) begin
      errors++;
      $display("FAIL midflight_restart state=%0d count=%0d wcount=%0d want 0/0/0",
               state_o, instr_count, w_instr_count);
    end
    @(posedge clk);
    #1;
    // Retire and reset in the same cycle: reset wins
    model_build(32'h08000010, 0, 0);
    run_trace(32'h08000010, 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_cnt = '0;
    #1;
    checks++;
    if (instr_count !== 32'd0 || state_o !== 4'(S_FETCH)) begin
      errors++;
      $display("FAIL rst_beats_retire count=%0d state=%0d want 0/0", instr_count, state_o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic [5:0]  legal_fn [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    int fw, mw;
    for (int k = 0; k < 45; k++) begin
      ins = $urandom;
      case ($urandom_range(0, 7))
        0: ins[31:26] = 6'h23;
        1: ins[31:26] = 6'h2B;
        2: begin ins[31:26] = 6'h00; ins[5:0] = legal_fn[$urandom_range(0, 4)]; end
        3: ins[31:26] = 6'h00;
        4: ins[31:26] = 6'h08;
        5: ins[31:26] = 6'h04;
        6: ins[31:26] = 6'h02;
        default: ;
      endcase
      fw = $urandom_range(0, 2);
      mw = $urandom_range(0, 3);
      model_build(ins, fw, mw);
      run_trace(ins, -1);
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL random ins=%h fw=%0d mw=%0d cyc%0d got=%h want=%h",
                   ins, fw, mw, i, obs_q[i], exp_q[i]);
        end
      end
      checks++;
      if (instr_count !== model_cnt || w_instr_count !== model_cnt[3:0]) begin
        errors++;
        $display("FAIL random_count ins=%h got=%0d/%0d want=%0d/%0d",
                 ins, instr_count, w_instr_count, model_cnt, model_cnt[3:0]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    zero = 1'b0;
    mem_ready = 1'b0;
    op = '0;
    func = '0;
    model_cnt = '0;
    #1;
    test_reset();
    test_add();
    test_sw_wait();
    test_lw_beq();
    test_j_illegal();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
